boot_load_ctrl: RTL and testbench

//  Sequences program load at power-up. Collects UART bytes into 32-bit little-endian words and writes them to instruction RAM.

---
 rtl/boot_load_ctrl_pkg.sv | 22 ++
 rtl/boot_load_ctrl_word_pack.sv | 30 +++
 rtl/boot_load_ctrl.sv | 135 +++++++++++++
 tb/tb_boot_load_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_load_ctrl_pkg.sv
// Shared constants for the boot loader: state encodings, default sizes, length check.
// Optional trailing-checksum feature is enabled by defining BOOT_CHECKSUM_EN.
package boot_load_ctrl_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BOOT_ADDR_W  = 14;
    localparam int unsigned BOOT_TIMEOUT = 1_000_000;
    localparam int unsigned LEN_W        = 16;

    localparam logic [2:0] S_LEN0 = 3'd0;
    localparam logic [2:0] S_LEN1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // True when a word count does not fit in a RAM of 2**addr_w words.
    function automatic logic len_exceeds(input logic [LEN_W-1:0] len, input int unsigned addr_w);
        return 32'(len) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/boot_load_ctrl_word_pack.sv
// Assembles little-endian 32-bit words from a byte stream; flags the word on its 4th byte.
module boot_word_pack
    import boot_load_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_byte_vld,
    input  logic [7:0]      i_byte,
    output logic            o_word_vld_c,
    output logic [XLEN-1:0] o_word_c
);

    logic [1:0]      r_byte_idx;
    logic [XLEN-9:0] r_lanes;

    // Lower three lanes shift down so the oldest byte lands in bits [7:0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_idx <= 2'd0;
            r_lanes    <= '0;
        end else if (i_byte_vld) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_lanes    <= {i_byte, r_lanes[XLEN-9:8]};
        end
    end

    assign o_word_vld_c = i_byte_vld && (r_byte_idx == 2'd3);
    assign o_word_c     = {i_byte, r_lanes};

endmodule

// File: rtl/boot_load_ctrl.sv
// Framed UART program loader: length header, data words to instruction RAM, core held until done.
// Define BOOT_CHECKSUM_EN to require a trailing modulo-256 data checksum byte.
module boot_load_ctrl
    import boot_load_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = BOOT_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = BOOT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_done,
    input  logic [7:0]        uart_byte,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] S_POST_DATA = S_CSUM;
`else
    localparam logic [2:0] S_POST_DATA = S_RUN;
`endif

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_word_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [LEN_W-1:0] w_len_full;
    logic             w_data_vld;
    logic             w_word_vld;
    logic [XLEN-1:0]  w_word;
    logic             w_last_word;
    logic             w_to_active;
    logic             w_to_expire;

    assign w_len_full  = {uart_byte, r_len[7:0]};
    assign w_data_vld  = uart_done && (r_state == S_DATA);
    assign w_last_word = (32'(r_word_cnt) + 32'd1) == 32'(r_len);
    assign w_to_active = (r_state == S_LEN1) || (r_state == S_DATA) || (r_state == S_CSUM);
    // A byte arriving on the terminal count wins over the abort.
    assign w_to_expire = w_to_active && !uart_done && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    boot_word_pack u_word_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte_vld   (w_data_vld),
        .i_byte       (uart_byte),
        .o_word_vld_c (w_word_vld),
        .o_word_c     (w_word)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= 8'd0;
        end else if (w_data_vld) begin
            r_sum <= r_sum + uart_byte;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN0: begin
                if (uart_done) w_state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (uart_done) begin
                    if (w_len_full == '0)                   w_state_nxt = S_RUN;
                    else if (len_exceeds(w_len_full, ADDR_W)) w_state_nxt = S_ERR;
                    else                                      w_state_nxt = S_DATA;
                end else if (w_to_expire) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (w_word_vld && w_last_word) w_state_nxt = S_POST_DATA;
                else if (w_to_expire)          w_state_nxt = S_ERR;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (uart_done)        w_state_nxt = (uart_byte == r_sum) ? S_RUN : S_ERR;
                else if (w_to_expire) w_state_nxt = S_ERR;
            end
`endif
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_LEN0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_to_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (uart_done && (r_state == S_LEN0)) r_len[7:0]  <= uart_byte;
            if (uart_done && (r_state == S_LEN1)) r_len[15:8] <= uart_byte;

            // Address is captured before the count advances.
            imem_we <= w_word_vld;
            if (w_word_vld) begin
                imem_addr  <= r_word_cnt[ADDR_W-1:0];
                imem_wdata <= w_word;
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end

            if (uart_done || !w_to_active) r_to_cnt <= '0;
            else                           r_to_cnt <= r_to_cnt + TO_W'(1);

            cpu_hold  <= (r_state != S_RUN);
            boot_done <= (r_state == S_RUN);
            boot_err  <= (r_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed and randomized frame checks for boot_load_ctrl against a byte-level frame model.
module tb_boot_load_ctrl;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned TO     = 16;
    localparam int          CAP    = 1 << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              uart_done;
    logic [7:0]        uart_byte;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              boot_done;
    logic              boot_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  fdat[$];

    boot_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_done  (uart_done),
        .uart_byte  (uart_byte),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        uart_done = 1'b1;
        uart_byte = b;
        tick(1);
        uart_done = 1'b0;
    endtask

    task automatic gap(input int gmin, input int gmax);
        tick(int'($urandom_range(gmax, gmin)));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        uart_done = 1'b0;
        uart_byte = 8'h00;
        tick(2);
        check("rst_we",    32'(imem_we),   32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata,     32'd0);
        check("rst_hold",  32'(cpu_hold),  32'd1);
        check("rst_done",  32'(boot_done), 32'd0);
        check("rst_err",   32'(boot_err),  32'd0);
        rst_n = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Sends a frame of n words using fdat as payload; checks every write and the final status.
    task automatic send_frame(input int n, input int gmin, input int gmax, input bit csum_bad);
        logic [7:0]  sum;
        logic [31:0] w;
        bit          legal;
        bit          ok;
        legal = (n <= CAP);
        sum   = 8'h00;
        send(8'(n));
        gap(gmin, gmax);
        send(8'(n >> 8));
        if (!legal) begin
            check("len_hold_t1", 32'(cpu_hold), 32'd1);
            tick(1);
            check("len_err",      32'(boot_err),  32'd1);
            check("len_err_hold", 32'(cpu_hold),  32'd1);
            check("len_err_done", 32'(boot_done), 32'd0);
            tick(2);
            check("len_err_nwr",  32'(wr_data_q.size()), 32'd0);
            return;
        end
        for (int i = 0; i < 4 * n; i++) begin
            gap(gmin, gmax);
            send(fdat[i]);
            sum = sum + fdat[i];
            if (i % 4 == 3) begin
                w = 32'(fdat[i-3]) + (32'(fdat[i-2]) << 8) + (32'(fdat[i-1]) << 16) + (32'(fdat[i]) << 24);
                check("we_lat",  32'(imem_we),   32'd1);
                check("wr_addr", 32'(imem_addr), 32'(i / 4));
                check("wr_data", imem_wdata,     w);
            end
        end
        ok = 1'b1;
        if (CSUM_EN && n > 0) begin
            gap(gmin, gmax);
            send(csum_bad ? sum + 8'd1 : sum);
            if (csum_bad) ok = 1'b0;
        end
        check("hold_t1", 32'(cpu_hold), 32'd1);
        tick(1);
        check("hold_t2", 32'(cpu_hold),  32'(!ok));
        check("done",    32'(boot_done), 32'(ok));
        check("err",     32'(boot_err),  32'(!ok));
        tick(2);
        check("nwrites", 32'(wr_data_q.size()), 32'(n));
    endtask

    task automatic rand_data(input int n);
        fdat.delete();
        for (int i = 0; i < 4 * n; i++) fdat.push_back(8'($urandom));
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        uart_done = 1'b0;
        uart_byte = 8'h00;
        tick(1);

        // Two-word frame with known instructions, then trailing bytes must be ignored.
        do_reset();
        fdat = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(2, 0, 0, 1'b0);
        check("t1_w0", wr_data_q[0], 32'h0000_0013);
        check("t1_w1", wr_data_q[1], 32'h0010_0093);
        check("t1_a1", wr_addr_q[1], 32'd1);
        for (int i = 0; i < 4; i++) send(8'hFF);
        tick(2);
        check("t1_ign_nwr",  32'(wr_data_q.size()), 32'd2);
        check("t1_ign_done", 32'(boot_done),        32'd1);

        // Empty frame.
        do_reset();
        fdat.delete();
        send_frame(0, 0, 0, 1'b0);

        // Abort after five data bytes: error on the 16th idle cycle.
        do_reset();
        send(8'd3);
        send(8'd0);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        tick(15);
        check("to_err_early", 32'(boot_err), 32'd0);
        tick(2);
        check("to_err",  32'(boot_err),  32'd1);
        check("to_hold", 32'(cpu_hold),  32'd1);
        check("to_done", 32'(boot_done), 32'd0);
        check("to_nwr",  32'(wr_data_q.size()), 32'd1);

        // Bytes arriving exactly on the terminal count are accepted.
        do_reset();
        rand_data(1);
        send_frame(1, 15, 15, 1'b0);

        // Reset mid-frame discards the partial word.
        do_reset();
        send(8'd2);
        send(8'd0);
        for (int i = 0; i < 6; i++) send(8'($urandom));
        do_reset();
        fdat = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(1, 0, 1, 1'b0);
        check("t4_word", wr_data_q[0], 32'hDEAD_BEEF);

        // Capacity boundary.
        do_reset();
        rand_data(5);
        send_frame(5, 0, 0, 1'b0);
        do_reset();
        rand_data(4);
        send_frame(4, 0, 2, 1'b0);
        check("t5_last_addr", wr_addr_q[3], 32'd3);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        fdat = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1, 0, 0, 1'b0);
        do_reset();
        fdat = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1, 0, 0, 1'b1);
`endif

        // Randomized frames.
        for (int k = 0; k < 24; k++) begin
            do_reset();
            n = int'($urandom_range(CAP + 1, 0));
            rand_data(n);
            send_frame(n, 0, (k % 4 == 0) ? 15 : 3, 1'($urandom_range(1, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
